// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response channel plus the IF/ID register outputs.
// Master is the fetch stage; slave is the memory and decode side.
interface if_fetch_stage_if;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;

   modport master (
      output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
      input  imem_ready, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
      output imem_ready, imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// LEGv8 fetch stage + IF/ID register, one outstanding imem request, all outputs registered.
// One-cycle fetch latency on zero-wait memory; a stalled returning word parks in a one-entry hold buffer.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_INC   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   stall,
   input  logic                   flush,
   input  logic [63:0]            branch_target,
   if_fetch_stage_if.master       bus
);

   typedef enum logic [1:0] {IDLE, FETCH, DROP, HOLD} state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [63:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;

   logic        fire;
   logic [63:0] pc_inc;
   logic        deliver;
   logic [63:0] deliver_pc;
   logic [31:0] deliver_instr;

   // A response only counts while our request is actually up.
   assign fire   = req_q & bus.imem_ready;
   assign pc_inc = pc_q + 64'(PC_INC);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_d         = req_q;
      addr_d        = addr_q;
      hold_pc_d     = hold_pc_q;
      hold_instr_d  = hold_instr_q;
      ifid_valid_d  = ifid_valid_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_instr_d  = ifid_instr_q;
      deliver       = 1'b0;
      deliver_pc    = addr_q;
      deliver_instr = bus.imem_rdata;

      case (state_q)
         IDLE: begin
            if (flush) pc_d = branch_target;
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_d;
         end
         FETCH: begin
            if (fire) begin
               if (flush) begin
                  pc_d   = branch_target;
                  addr_d = branch_target;
               end else if (stall) begin
                  hold_pc_d    = addr_q;
                  hold_instr_d = bus.imem_rdata;
                  pc_d         = pc_inc;
                  req_d        = 1'b0;
                  state_d      = HOLD;
               end else begin
                  deliver = 1'b1;
                  pc_d    = pc_inc;
                  addr_d  = pc_inc;
               end
            end else if (flush) begin
               // Request must stay up on its old address until memory answers.
               pc_d    = branch_target;
               state_d = DROP;
            end
         end
         DROP: begin
            if (flush) pc_d = branch_target;
            if (fire) begin
               state_d = FETCH;
               addr_d  = pc_d;
            end
         end
         HOLD: begin
            if (flush) begin
               pc_d         = branch_target;
               addr_d       = branch_target;
               req_d        = 1'b1;
               hold_pc_d    = 64'h0;
               hold_instr_d = 32'h0;
               state_d      = FETCH;
            end else if (!stall) begin
               deliver       = 1'b1;
               deliver_pc    = hold_pc_q;
               deliver_instr = hold_instr_q;
               req_d         = 1'b1;
               addr_d        = pc_q;
               state_d       = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase

      // IF/ID priority: flush > stall > new word > bubble.
      if (flush) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = 32'h0;
      end else if (!stall) begin
         if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = deliver_pc;
            ifid_instr_d = deliver_instr;
         end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'h0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
         hold_pc_q    <= 64'h0;
         hold_instr_q <= 32'h0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= 64'h0;
         ifid_instr_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
      end
   end

   assign bus.imem_req   = req_q;
   assign bus.imem_addr  = addr_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.ifid_pc    = ifid_pc_q;
   assign bus.ifid_instr = ifid_instr_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 64-bit LEGv8 ARM CPU. It holds the PC, issues one outstanding instruction-memory request at a time, and captures the returned 32-bit word into IF/ID. The decode stage and the immediate sign extender read that word from IF/ID. Stall comes from the hazard unit; flush/redirect comes from branch resolution.

Parameters:
RESET_PC, 64'h0, PC value loaded at reset; first fetch address.
PC_INC, 4, byte increment per sequential fetch.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
stall  input  1  hazard unit: freeze IF/ID and PC advance.
flush  input  1  branch taken: discard in-flight/held instruction, redirect PC.
branch_target  input  64  redirect address, sampled when flush=1.
imem_req  output  1  fetch request valid.
imem_addr  output  64  fetch byte address.
imem_ready  input  1  data valid on imem_rdata this cycle; completes the request.
imem_rdata  input  32  fetched instruction word.
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
ifid_pc  output  64  address of the instruction in IF/ID.
ifid_instr  output  32  instruction word in IF/ID (32'h0 when bubble).

Behaviour:
- Reset (rst_n=0, async): pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC; ifid_valid=0; ifid_pc=0; ifid_instr=0; hold buffer cleared.
- States: IDLE, FETCH, DROP, HOLD. Registered state; all outputs registered.
- IDLE: one cycle after reset release -> FETCH with imem_addr=pc.
- Request rule: while imem_req=1 and imem_ready=0, imem_addr is stable. A request is never withdrawn before imem_ready. imem_ready with imem_req=0 is ignored.
- FETCH, imem_ready=1:
  - flush=1: drop the word; pc<=branch_target; next request at branch_target; stay FETCH.
  - stall=1: word and its address go to the hold buffer; pc<=pc+PC_INC; -> HOLD (imem_req=0).
  - else: ifid_instr<=imem_rdata, ifid_pc<=imem_addr, ifid_valid<=1; pc<=pc+PC_INC; next request issued the following cycle at the new pc (one-cycle fetch latency with zero-wait memory); stay FETCH.
- FETCH, imem_ready=0:
  - flush=1: pc<=branch_target; -> DROP. imem_req stays 1 and imem_addr keeps the old address.
  - else: wait.
- DROP: on imem_ready=1, discard the data -> FETCH at pc. A further flush in DROP overwrites pc with the newest branch_target.
- HOLD: imem_req=0.
  - flush=1: discard the hold buffer; pc<=branch_target; -> FETCH.
  - stall=0 (no flush): IF/ID<=hold buffer (valid=1); -> FETCH.
- IF/ID update priority per cycle: flush > stall > new data > bubble.
  - flush=1: ifid_valid<=0, ifid_instr<=0; ifid_pc unchanged.
  - stall=1 (no flush): IF/ID holds all fields.
  - No flush, no stall, no word delivered: ifid_valid<=0, ifid_instr<=0.
- Simultaneous flush and stall: flush wins for both IF/ID and PC.
- Arithmetic: pc+PC_INC is modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. branch_target is used as given, with no alignment check.
- Reset mid-request: all state cleared immediately. A memory response arriving after reset release while in IDLE is ignored.

Test Plan:
- Reset, zero-wait memory returning addr-derived words -> imem_addr sequence 0,4,8,C; ifid_pc 0,4,8 with ifid_valid=1 from the 3rd cycle after rst_n rise; ifid_instr matches memory.
- imem_ready delayed 3 cycles on addr 8 -> imem_req/imem_addr=8 held 4 cycles; IF/ID shows bubbles (valid=0, instr=0) meanwhile; next request at C.
- stall=1 for 2 cycles while word at 0x10 returns -> IF/ID keeps 0x0C contents; on stall release ifid_pc=0x10 from the hold buffer; next request at 0x14.
- flush=1 with branch_target=0x400 while the request at 0x20 is pending (ready 2 cycles later) -> 0x20 data discarded, ifid_valid=0; next imem_addr=0x400; ifid_pc=0x400 later.
- flush and stall together in HOLD -> hold buffer dropped, ifid_valid=0, next fetch at branch_target.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> fetches at ...FFFC then 0; rst_n pulsed low mid-wait -> imem_req=0 immediately, fetch restarts at RESET_PC.
